cacheline_burst_adapter: RTL
============================

// Module: cacheline_burst_adapter
// PURPOSE
//  Memory-side responder for the cache's pmem line interface. Accepts one 256-bit line read or
//  write (held until line_resp) and performs it on a 64-bit burst memory port as BEATS beats.
//  Sits between the cache/arbiter pmem_* signals and the physical-memory burst bus.
// PARAMETERS
//  LINE_WIDTH  256  bits per cache line; must be BEAT_WIDTH*BEATS
//  BEAT_WIDTH  64   bits per burst beat
//  ADDR_WIDTH  32   byte address width
//  (derived) BEATS = LINE_WIDTH/BEAT_WIDTH = 4; OFFS = log2(LINE_WIDTH/8) = 5
// PORTS
//  clk            in   1           clock; all state on posedge
//  rst            in   1           asynchronous, active-high reset
//  line_read      in   1           line read request; held until line_resp
//  line_write     in   1           line write request; held until line_resp
//  line_address   in   ADDR_WIDTH  line byte address; low OFFS bits ignored
//  line_wdata     in   LINE_WIDTH  write line; bits [63:0] = beat 0
//  line_resp      out  1           one-cycle completion pulse
//  line_rdata     out  LINE_WIDTH  assembled read line; valid with line_resp, held until next read
//  burst_read     out  1           burst read strobe; high for whole burst
//  burst_write    out  1           burst write strobe; high for whole burst
//  burst_address  out  ADDR_WIDTH  {line_address[ADDR_WIDTH-1:OFFS], OFFS'b0}; stable for burst
//  burst_wdata    out  BEAT_WIDTH  current write beat
//  burst_rdata    in   BEAT_WIDTH  read beat, valid when burst_resp=1
//  burst_resp     in   1           one beat transferred this cycle
// BEHAVIOUR
//  States: IDLE, READ, WRITE, DONE. Beat counter cnt[1:0]; line buffer buf[LINE_WIDTH-1:0].
//  Reset (async, any state): state=IDLE, cnt=0, buf=0, addr reg=0. Outputs: line_resp=0,
//   burst_read=0, burst_write=0, burst_address=0, burst_wdata=0, line_rdata=0.
//   Reset mid-burst aborts it at once; no line_resp for the aborted request.
//  IDLE: line_write -> WRITE (buf<=line_wdata, addr<=aligned line_address, cnt<=0);
//   else line_read -> READ (addr latched, cnt<=0). Both high (illegal): write wins.
//  READ: burst_read=1. Each cycle with burst_resp: buf[cnt*64 +: 64]<=burst_rdata, cnt++;
//   on beat cnt==BEATS-1 -> DONE. No burst_resp: hold (unbounded wait states).
//  WRITE: burst_write=1, burst_wdata=buf[cnt*64 +: 64]. burst_resp advances cnt;
//   last beat -> DONE.
//  DONE: line_resp=1 for exactly one cycle; line_rdata=buf; -> IDLE unconditionally.
//   Initiator drops request in the cycle it sees line_resp, so no re-trigger.
//  line_rdata driven from buf at all times; contents defined only after read completion.
//  burst_resp while in IDLE/DONE: ignored. line_* inputs changing mid-burst: ignored (latched).
//  Latency, zero-wait memory: request seen in IDLE at cycle 0, beats at cycles 1-4,
//   line_resp at cycle 5. Next request accepted at cycle 6 at earliest.
//  burst_read and burst_write are never high together; both are 0 in IDLE/DONE.
//  Counter wraps to 0 on the last beat; no partial lines are ever reported.
// TESTING
//  T1 read, zero wait: line_read, addr 0x0000_1234; beats 0x11..11,0x22..22,0x33..33,0x44..44
//   -> burst_address=0x0000_1220, line_resp at cycle 5, line_rdata={44..,33..,22..,11..}.
//  T2 write with waits: line_write, line_wdata={D3,D2,D1,D0}, burst_resp every 2nd cycle
//   -> burst_wdata D0,D1,D2,D3 in order, each held until its resp; one line_resp after D3.
//  T3 reset mid-read: assert rst after 2 beats -> all outputs 0 same cycle; after release,
//   a new read completes correctly with fresh data; no stray line_resp.
//  T4 back-to-back: write then read to same line -> two line_resp pulses, strobes never overlap,
//   read returns data from memory model matching the written line.
//  T5 illegal both high: line_read=line_write=1 -> WRITE burst performed, burst_read stays 0.
//  T6 spurious burst_resp in IDLE for 3 cycles -> no state change, line_resp stays 0.

Source files
------------

// File: rtl/cacheline_burst_adapter.sv
// Bridges a held 256-bit line request onto a 64-bit burst memory port.
// Each line request becomes BEATS beats, and line_resp pulses once when the burst completes.
module cacheline_burst_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [ADDR_WIDTH-1:0] line_address,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic                  line_resp,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [ADDR_WIDTH-1:0] burst_address,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFFS  = $clog2(LINE_WIDTH / 8);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg;
  logic [LINE_WIDTH-1:0]   line_buf_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    last_beat;
  logic [ADDR_WIDTH-1:0]   aligned_address;
  logic                    unused_offset_bits;

  assign last_beat       = burst_resp && (cnt_reg == CW'(BEATS - 1));
  assign aligned_address = {line_address[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
  // Byte offset within the line never reaches the burst port.
  assign unused_offset_bits = ^line_address[OFFS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (line_write)     state_next = WRITE;
        else if (line_read) state_next = READ;
      end
      READ:    if (last_beat) state_next = DONE;
      WRITE:   if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      line_buf_reg <= '0;
      addr_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (line_write) begin
            line_buf_reg <= line_wdata;
            addr_reg     <= aligned_address;
            cnt_reg      <= '0;
          end else if (line_read) begin
            addr_reg <= aligned_address;
            cnt_reg  <= '0;
          end
        end
        READ: begin
          if (burst_resp) begin
            line_buf_reg[int'(cnt_reg)*BEAT_WIDTH +: BEAT_WIDTH] <= burst_rdata;
            cnt_reg <= last_beat ? '0 : cnt_reg + CW'(1);
          end
        end
        WRITE: begin
          if (burst_resp) cnt_reg <= last_beat ? '0 : cnt_reg + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    line_resp   = 1'b0;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    burst_wdata = '0;
    case (state_reg)
      READ:  burst_read = 1'b1;
      WRITE: begin
        burst_write = 1'b1;
        burst_wdata = line_buf_reg[int'(cnt_reg)*BEAT_WIDTH +: BEAT_WIDTH];
      end
      DONE:  line_resp = 1'b1;
      default: ;
    endcase
  end

  assign line_rdata    = line_buf_reg;
  assign burst_address = addr_reg;

endmodule
